// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between the EX/MEM and MEM/WB boundaries.
// Issues data-bus accesses over a req/ack handshake with byte-lane steering
// and load extension, stalls upstream while an access is outstanding, and
// registers the writeback value.
// Optional: define MEM_TIMEOUT_EN to enable an ack watchdog (TIMEOUT_CYCLES).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_ALU_out,
    input  logic [31:0] i_Store_Data,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_PC_plus_4,
    input  logic        i_RegWrite,
    input  logic        i_MemWrite,
    input  logic        i_MemRead,
    input  logic [1:0]  i_WDSel,
    input  logic [2:0]  i_DMType,
    output logic        o_stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_RegWrite,
    output logic        o_misalign,
    output logic        o_bus_err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic [1:0]  r_addr_lo;   // low address bits of the access in flight
    logic [2:0]  r_dmtype;    // access type of the access in flight

    logic        w_access;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_sel;

    assign w_access   = i_MemRead | i_MemWrite;
    assign w_is_half  = (i_DMType == 3'b001) || (i_DMType == 3'b010);
    assign w_is_byte  = (i_DMType == 3'b011) || (i_DMType == 3'b100);
    assign w_is_word  = ~w_is_half & ~w_is_byte;
    assign w_misalign = (w_is_half & i_ALU_out[0]) | (w_is_word & (|i_ALU_out[1:0]));

    // Store lane replication and byte enables; reads always enable all lanes
    always_comb begin
        w_wdata = i_Store_Data;
        w_be    = 4'b1111;
        if (w_is_byte) begin
            w_wdata = {4{i_Store_Data[7:0]}};
            w_be    = 4'b0001 << i_ALU_out[1:0];
        end else if (w_is_half) begin
            w_wdata = {2{i_Store_Data[15:0]}};
            w_be    = i_ALU_out[1] ? 4'b1100 : 4'b0011;
        end
        if (!i_MemWrite) begin
            w_be = 4'b1111;
        end
    end

    // Load lane extraction and extension, using the latched access attributes
    always_comb begin
        w_byte = dbus_rdata[{r_addr_lo, 3'b000} +: 8];
        w_half = r_addr_lo[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (r_dmtype)
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = {16'h0000, w_half};
            3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h000000, w_byte};
            default: w_load = dbus_rdata;
        endcase
    end

    // Writeback source select; 11 falls back to the ALU result
    always_comb begin
        case (i_WDSel)
            2'b01:   w_sel = w_load;
            2'b10:   w_sel = i_PC_plus_4;
            default: w_sel = i_ALU_out;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_bus_err;

    assign w_timeout = (r_state == S_BUSY) && !dbus_ack &&
                       (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign o_bus_err = r_bus_err;

    // Watchdog: counts BUSY cycles without ack, held at zero while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= 16'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (r_state == S_IDLE) begin
                r_tmo_cnt <= 16'd0;
            end else if (!dbus_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // Hold upstream while an access is being issued or awaits its ack
    assign o_stall = (r_state == S_IDLE) ? (w_access & ~w_misalign)
                                         : ~(dbus_ack | w_timeout);

    // Access FSM with registered bus and MEM/WB outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr_lo     <= 2'b00;
            r_dmtype      <= 3'b000;
            dbus_req      <= 1'b0;
            dbus_we       <= 1'b0;
            dbus_addr     <= 32'h0;
            dbus_wdata    <= 32'h0;
            dbus_be       <= 4'h0;
            o_wb_data     <= 32'h0;
            o_wb_rd       <= 5'd0;
            o_wb_RegWrite <= 1'b0;
            o_misalign    <= 1'b0;
        end else begin
            o_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access && !w_misalign) begin
                        dbus_req      <= 1'b1;
                        dbus_we       <= i_MemWrite;
                        dbus_addr     <= {i_ALU_out[31:2], 2'b00};
                        dbus_wdata    <= w_wdata;
                        dbus_be       <= w_be;
                        r_addr_lo     <= i_ALU_out[1:0];
                        r_dmtype      <= i_DMType;
                        o_wb_RegWrite <= 1'b0;
                        r_state       <= S_BUSY;
                    end else if (w_access) begin
                        o_misalign    <= 1'b1;
                        o_wb_RegWrite <= 1'b0;
                    end else begin
                        o_wb_data     <= w_sel;
                        o_wb_rd       <= i_rd;
                        o_wb_RegWrite <= i_RegWrite;
                    end
                end
                default: begin
                    if (dbus_ack) begin
                        o_wb_data     <= w_sel;
                        o_wb_rd       <= i_rd;
                        o_wb_RegWrite <= i_RegWrite;
                        dbus_req      <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (w_timeout) begin
                        o_wb_RegWrite <= 1'b0;
                        dbus_req      <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        o_wb_RegWrite <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized transactions for mem_stage, checked
// against a behavioural model of the access/steering/extension rules.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_ALU_out, i_Store_Data, i_PC_plus_4;
    logic [4:0]  i_rd;
    logic        i_RegWrite, i_MemWrite, i_MemRead;
    logic [1:0]  i_WDSel;
    logic [2:0]  i_DMType;
    logic        o_stall, dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_RegWrite, o_misalign, o_bus_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_ALU_out(i_ALU_out), .i_Store_Data(i_Store_Data), .i_rd(i_rd),
        .i_PC_plus_4(i_PC_plus_4), .i_RegWrite(i_RegWrite),
        .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead), .i_WDSel(i_WDSel),
        .i_DMType(i_DMType), .o_stall(o_stall), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_RegWrite(o_wb_RegWrite),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] dm); // bytes per access
        if (dm == 3'd1 || dm == 3'd2) return 2;
        if (dm == 3'd3 || dm == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] dm, input logic [1:0] a,
                                           input logic [31:0] rd);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rd >> (8 * a);
        b  = sh[7:0];
        h  = 16'(rd >> (16 * a[1]));
        case (dm)
            3'd1:    return 32'($signed(h));
            3'd2:    return 32'(h);
            3'd3:    return 32'($signed(b));
            3'd4:    return 32'(b);
            default: return rd;
        endcase
    endfunction

    task automatic set_nop();
        i_MemRead = 0; i_MemWrite = 0; i_RegWrite = 0; i_WDSel = 0; i_DMType = 0;
        i_ALU_out = 0; i_Store_Data = 0; i_PC_plus_4 = 0; i_rd = 0;
        dbus_ack = 0;
    endtask

    // One instruction through the stage; starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] pc4, input logic [4:0] rd,
                           input logic rw, input logic mw, input logic mr,
                           input logic [1:0] wds, input logic [2:0] dm,
                           input int dly, input logic [31:0] rdat);
        int size, stalls;
        logic misal;
        logic [31:0] e_wd, e_wb;
        logic [3:0]  e_be;
        i_ALU_out = alu; i_Store_Data = sd; i_PC_plus_4 = pc4; i_rd = rd;
        i_RegWrite = rw; i_MemWrite = mw; i_MemRead = mr; i_WDSel = wds; i_DMType = dm;
        dbus_rdata = $urandom;
        size  = m_size(dm);
        misal = (alu % size) != 0;
        if (!(mr || mw)) begin
            dbus_ack = 1'($urandom_range(0, 1));   // stray ack while idle
            @(negedge clk);
            check("nop_stall", o_stall, 0);
            check("nop_req", dbus_req, 0);
            @(posedge clk); #1;
            e_wb = (wds == 2'd2) ? pc4 : alu;
            check("nop_wb_data", o_wb_data, e_wb);
            check("nop_wb_rd", o_wb_rd, rd);
            check("nop_wb_we", o_wb_RegWrite, rw);
            check("nop_misalign", o_misalign, 0);
            set_nop();
        end else if (misal) begin
            @(negedge clk);
            check("mis_stall", o_stall, 0);
            @(posedge clk); #1;
            check("mis_flag", o_misalign, 1);
            check("mis_wb_we", o_wb_RegWrite, 0);
            check("mis_req", dbus_req, 0);
            set_nop();
            @(posedge clk); #1;
            check("mis_pulse_end", o_misalign, 0);
        end else begin
            e_wd = sd; e_be = 4'hF;
            if (mw && size == 1) begin e_wd = sd[7:0] * 32'h01010101; e_be = 4'(1 << alu[1:0]); end
            if (mw && size == 2) begin e_wd = sd[15:0] * 32'h00010001; e_be = alu[1] ? 4'hC : 4'h3; end
            dbus_ack = 0;
            stalls = 0;
            @(negedge clk);
            check("acc_req_pre", dbus_req, 0);
            if (o_stall) stalls++;
            @(posedge clk); #1;
            check("acc_req", dbus_req, 1);
            check("acc_we", dbus_we, mw);
            check("acc_addr", dbus_addr, alu & 32'hFFFF_FFFC);
            check("acc_be", dbus_be, e_be);
            if (mw) check("acc_wdata", dbus_wdata, e_wd);
            check("acc_bubble", o_wb_RegWrite, 0);
            for (int k = 0; k <= dly; k++) begin
                dbus_ack   = (k == dly);
                dbus_rdata = (k == dly) ? rdat : $urandom;
                @(negedge clk);
                check("busy_req", dbus_req, 1);
                check("busy_addr", dbus_addr, alu & 32'hFFFF_FFFC);
                if (o_stall) stalls++;
                @(posedge clk); #1;
                dbus_ack = 0;
            end
            e_wb = (wds == 2'd1) ? m_load(dm, alu[1:0], rdat) : (wds == 2'd2) ? pc4 : alu;
            check("done_req", dbus_req, 0);
            check("done_wb_data", o_wb_data, e_wb);
            check("done_wb_rd", o_wb_rd, rd);
            check("done_wb_we", o_wb_RegWrite, rw);
            check("done_misalign", o_misalign, 0);
            check("done_bus_err", o_bus_err, 0);
            check("stall_cycles", stalls, dly + 1);
            set_nop();
        end
        $display("txn alu=%08h mr=%0b mw=%0b dm=%0d wds=%0d dly=%0d wb=%08h rd=%0d we=%0b",
                 alu, mr, mw, dm, wds, dly, o_wb_data, o_wb_rd, o_wb_RegWrite);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic mr, mw;
        logic [1:0] wds;
        reset = 1;
        set_nop();
        dbus_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", dbus_req, 0);
        check("rst_be", dbus_be, 0);
        check("rst_addr", dbus_addr, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_wb_we", o_wb_RegWrite, 0);
        check("rst_stall", o_stall, 0);
        check("rst_bus_err", o_bus_err, 0);
        reset = 0;

        // ALU op
        run_txn(32'h1234, 0, 0, 5'd5, 1, 0, 0, 2'd0, 3'd0, 0, 0);
        check("alu_const", o_wb_data, 32'h1234);
        // lb signed at 0x103, ack in the fourth BUSY cycle
        run_txn(32'h103, 0, 32'h44, 5'd7, 1, 0, 1, 2'd1, 3'd3, 3, 32'h80AABBCC);
        check("lb_const", o_wb_data, 32'hFFFFFF80);
        // sh at 0x202, immediate ack
        run_txn(32'h202, 32'hDEADBEEF, 0, 5'd0, 0, 1, 0, 2'd0, 3'd1, 0, 32'h0);
        check("sh_wdata_const", dbus_wdata, 32'hBEEFBEEF);
        check("sh_be_const", dbus_be, 4'b1100);
        // misaligned lw then lhu
        run_txn(32'h101, 0, 0, 5'd3, 1, 0, 1, 2'd1, 3'd0, 0, 0);
        run_txn(32'h203, 0, 0, 5'd4, 1, 0, 1, 2'd1, 3'd2, 0, 0);

        // reset during BUSY, then a late ack
        i_ALU_out = 32'h40; i_MemRead = 1; i_RegWrite = 1; i_WDSel = 2'd1; i_rd = 5'd9;
        @(posedge clk); #1;
        check("rb_req", dbus_req, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        set_nop();
        check("rb_req_drop", dbus_req, 0);
        check("rb_addr", dbus_addr, 0);
        check("rb_wb_data", o_wb_data, 0);
        check("rb_wb_we", o_wb_RegWrite, 0);
        dbus_ack = 1; dbus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rb_stall", o_stall, 0);
        @(posedge clk); #1;
        dbus_ack = 0;
        check("rb_late_ack_we", o_wb_RegWrite, 0);
        check("rb_late_ack_req", dbus_req, 0);

`ifdef MEM_TIMEOUT_EN
        i_ALU_out = 32'h80; i_MemRead = 1; i_RegWrite = 1; i_WDSel = 2'd1; i_rd = 5'd2;
        @(posedge clk); #1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            check("tmo_req", dbus_req, 1);
            check("tmo_stall", o_stall, (k != TMO - 1));
            @(posedge clk); #1;
        end
        check("tmo_req_drop", dbus_req, 0);
        check("tmo_bus_err", o_bus_err, 1);
        check("tmo_wb_we", o_wb_RegWrite, 0);
        set_nop();
        @(posedge clk); #1;
        check("tmo_err_pulse", o_bus_err, 0);
        run_txn(32'h80, 0, 0, 5'd2, 1, 0, 1, 2'd1, 3'd0, TMO - 1, 32'h12345678);
`endif

        // randomized back-to-back traffic
        for (int n = 0; n < 80; n++) begin
            mr  = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
            mw  = 1'($urandom);
            wds = 2'($urandom);
            if (!(mr || mw) && wds == 2'd1) wds = 2'd0;
            run_txn({$urandom_range(0, 32'h0FFF_FFFF), 4'($urandom)}, $urandom, $urandom,
                    5'($urandom), 1'($urandom), mw, mr, wds, 3'($urandom),
                    $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
